receiver_deserializer: RTL and testbench



---
 rtl/receiver_deserializer_pkg.sv | 10 +
 rtl/receiver_deserializer_if.sv | 14 +
 rtl/receiver_deserializer.sv | 68 ++++++
 tb/tb_receiver_deserializer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/receiver_deserializer_pkg.sv
// Shared definitions for the serial frame link (sender and receiver sides).
package receiver_deserializer_pkg;
    localparam int   FRAME_WIDTH = 40;
    localparam logic START_BIT   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;
endpackage

// File: rtl/receiver_deserializer_if.sv
// Parallel output channel of the deserializer: valid/ready word plus overrun pulse.
interface receiver_deserializer_if
    import receiver_deserializer_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    modport master (output out_data, output out_valid, output overrun, input out_ready);
    modport slave  (input out_data, input out_valid, input overrun, output out_ready);
endinterface

// File: rtl/receiver_deserializer.sv
// Bit-clock domain serial-to-parallel receiver: start bit then WIDTH bits MSB first,
// delivered through a one-deep holding register with overrun reporting.
module receiver_deserializer
    import receiver_deserializer_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sin,
    output logic                    busy,
    receiver_deserializer_if.master rx
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] frame;
    logic             last_bit;
    logic             load;

    // The LSB is taken straight from sin so the word is complete on the same edge.
    assign frame    = {shift[WIDTH-2:0], sin};
    assign last_bit = (state == RECV) && (cnt == CW'(WIDTH - 1));
    assign load     = last_bit && (!rx.out_valid || rx.out_ready);
    assign busy     = (state == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sin == START_BIT) state_nxt = RECV;
            RECV: if (last_bit)         state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            shift        <= '0;
            rx.out_data  <= '0;
            rx.out_valid <= 1'b0;
            rx.overrun   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (sin == START_BIT) cnt <= '0;
            end else begin
                shift <= frame;
                cnt   <= last_bit ? '0 : cnt + CW'(1);
            end

            // A completing frame that cannot be loaded is dropped; the old word stays.
            rx.overrun <= last_bit && !load;
            if (load) begin
                rx.out_data  <= frame;
                rx.out_valid <= 1'b1;
            end else if (!last_bit && rx.out_valid && rx.out_ready) begin
                rx.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_receiver_deserializer.sv
// Directed plus randomized frames against a word-level model of the holding register.
module tb_receiver_deserializer;
    import receiver_deserializer_pkg::*;

    localparam int W = FRAME_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    logic sin;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ovr;

    receiver_deserializer_if #(.WIDTH(W)) rx_if ();

    receiver_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .busy  (busy),
        .rx    (rx_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input bit exp_busy);
        chk("out_valid", W'(rx_if.out_valid), W'(m_valid));
        chk("out_data",  rx_if.out_data, m_data);
        chk("overrun",   W'(rx_if.overrun), W'(m_ovr));
        chk("busy",      W'(busy), W'(exp_busy));
    endtask

    // One bit-clock: drive inputs, advance the model on the edge, compare just after.
    task automatic step(input logic s, input logic rdy, input bit comp,
                        input logic [W-1:0] fv, input bit exp_busy);
        sin = s;
        rx_if.out_ready = rdy;
        @(posedge clk);
        m_ovr = 1'b0;
        if (comp) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = fv;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check_all(exp_busy);
    endtask

    // 0: never ready, 1: always ready, 2: random, 3: ready only on the completion edge
    function automatic logic rdy_of(input int mode, input bit last);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'($urandom_range(0, 1));
            default: return logic'(last);
        endcase
    endfunction

    task automatic send(input logic [W-1:0] d, input int mode);
        step(START_BIT, rdy_of(mode, 1'b0), 1'b0, '0, 1'b1);
        for (int i = 1; i <= W; i++)
            step(d[W-i], rdy_of(mode, i == W), i == W, d, i < W);
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++)
            step(1'b0, rdy_of(mode, 1'b0), 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [63:0] r;
        rst_n = 1'b0;
        sin = 1'b0;
        rx_if.out_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ovr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single frame
        idle(5, 1);
        send(40'hA5_1234_5678, 1);
        idle(3, 1);

        // back-to-back, no idle gap
        send(40'h00_0000_0001, 1);
        send(40'h80_0000_0000, 1);
        idle(3, 1);

        // stall and overrun, then drain
        send(40'h11, 0);
        idle(2, 0);
        send(40'h22, 0);
        idle(2, 0);
        idle(2, 1);

        // accept and complete on the same edge
        send(40'h33, 0);
        idle(1, 0);
        send(40'h44, 3);
        idle(1, 0);
        idle(2, 1);

        // reset in the middle of a frame
        step(START_BIT, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 1; i <= 20; i++) step(logic'(i & 1), 1'b1, 1'b0, '0, 1'b1);
        rst_n = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ovr   = 1'b0;
        #2;
        check_all(1'b0);
        sin = 1'b1;
        @(posedge clk);
        #1;
        check_all(1'b0);
        sin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(40'hFF_FFFF_FFFF, 1);
        idle(3, 1);

        // all-zero payload, then quiet line
        send(40'h0, 1);
        idle(10, 1);

        // randomized frames, gaps and consumer stalls
        for (int k = 0; k < 25; k++) begin
            r = {$urandom(), $urandom()};
            send(r[W-1:0], 2);
            idle(int'($urandom_range(0, 3)), 2);
        end
        idle(4, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
